// File: rtl/acc_ram_ctrl_pkg.sv
// Shared types and helpers for the accumulator-computer main memory controller.
// Optional parity storage is enabled with the ACC_RAM_PARITY_EN macro.
package acc_mem_pkg;

    typedef enum logic {CLEAR, RUN} state_e;

    localparam int RD_LAT_MAX = 4;

    // Widest data word the parity helper accepts; narrower words are zero-extended,
    // which leaves the parity unchanged.
    localparam int PAR_DW_MAX = 64;

    // Even-parity bit: makes the total count of ones (data + bit) even.
    function automatic logic even_parity(input logic [PAR_DW_MAX-1:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/acc_ram_ctrl_if.sv
// Request/response bus between the CPU control unit and the memory controller.
// Parity sideband signals exist only when ACC_RAM_PARITY_EN is defined.
interface acc_ram_ctrl_if #(
    parameter int DW = 16,
    parameter int AW = 7
);
    logic          req_valid;
    logic          req_ready;
    logic          req_wr;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
`ifdef ACC_RAM_PARITY_EN
    logic          inj_perr;
    logic          rsp_perr;

    modport master (output req_valid, req_wr, req_addr, req_wdata, inj_perr,
                    input  req_ready, rsp_valid, rsp_rdata, rsp_perr);
    modport slave  (input  req_valid, req_wr, req_addr, req_wdata, inj_perr,
                    output req_ready, rsp_valid, rsp_rdata, rsp_perr);
`else
    modport master (output req_valid, req_wr, req_addr, req_wdata,
                    input  req_ready, rsp_valid, rsp_rdata);
    modport slave  (input  req_valid, req_wr, req_addr, req_wdata,
                    output req_ready, rsp_valid, rsp_rdata);
`endif
endinterface

// File: rtl/acc_ram_array.sv
// Plain single-port synchronous storage: one write, one registered read per cycle.
// Word width includes the parity bit when ACC_RAM_PARITY_EN is defined.
module acc_ram_array #(
    parameter int WW    = 16,
    parameter int AW    = 7,
    parameter int DEPTH = 128
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic [WW-1:0] wdata,
    output logic [WW-1:0] rdata
);
    logic [WW-1:0] mem [DEPTH];

    // storage write; contents are not reset
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

    // registered read port, holds its value between reads
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  rdata <= '0;
        else if (re) rdata <= mem[addr];
    end
endmodule

// File: rtl/acc_ram_ctrl.sv
// Memory controller: post-reset clear sequencer, address range check and
// read-latency pipeline in front of acc_ram_array.
// Define ACC_RAM_PARITY_EN to store and check an even-parity bit per word.
module acc_ram_ctrl
    import acc_mem_pkg::*;
#(
    parameter int DW         = 16,
    parameter int AW         = 7,
    parameter int DEPTH      = 128,
    parameter int RD_LAT     = 1,
    parameter int INIT_CLEAR = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    acc_ram_ctrl_if.slave bus,
    output logic          init_busy
);
`ifdef ACC_RAM_PARITY_EN
    localparam int PW = 1;
`else
    localparam int PW = 0;
`endif
    localparam int WW  = DW + PW;
    localparam int LAT = (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : ((RD_LAT < 1) ? 1 : RD_LAT);
    localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

    state_e        state;
    logic [AW-1:0] clr_cnt;
    logic          in_range, accept, rd_acc, wr_acc, clearing;
    logic          arr_we, arr_re;
    logic [AW-1:0] arr_addr;
    logic [WW-1:0] arr_wdata, arr_rdata;
    logic          oor_q;
    logic [WW-1:0] s1_word, out_word;
    logic [LAT-1:0] vld_pipe;

    assign in_range = ({1'b0, bus.req_addr} < DEPTH_W);
    assign accept   = bus.req_valid & bus.req_ready;
    assign rd_acc   = accept & ~bus.req_wr;
    assign wr_acc   = accept & bus.req_wr & in_range;
    assign clearing = (state == CLEAR);

    // clear sequence owns the port; req_ready is low then, so no request can collide
    assign arr_we   = clearing | wr_acc;
    assign arr_re   = rd_acc & in_range;
    assign arr_addr = clearing ? clr_cnt : bus.req_addr;

`ifdef ACC_RAM_PARITY_EN
    // parity sits above the data bits; all-zero word has parity 0
    assign arr_wdata = clearing ? '0
                     : {even_parity(PAR_DW_MAX'(bus.req_wdata)) ^ bus.inj_perr, bus.req_wdata};
    // after the array the top bit becomes the mismatch flag
    assign s1_word   = oor_q ? '0
                     : {arr_rdata[DW] ^ even_parity(PAR_DW_MAX'(arr_rdata[DW-1:0])), arr_rdata[DW-1:0]};
    assign bus.rsp_perr = out_word[DW];
`else
    assign arr_wdata = clearing ? '0 : bus.req_wdata;
    assign s1_word   = oor_q ? '0 : arr_rdata;
`endif

    assign bus.rsp_valid = vld_pipe[LAT-1];
    assign bus.rsp_rdata = out_word[DW-1:0];

    acc_ram_array #(.WW(WW), .AW(AW), .DEPTH(DEPTH)) u_array (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (arr_we),
        .re    (arr_re),
        .addr  (arr_addr),
        .wdata (arr_wdata),
        .rdata (arr_rdata)
    );

    // clear sequencer and run-state handshake, all outputs registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= (INIT_CLEAR != 0) ? CLEAR : RUN;
            clr_cnt       <= '0;
            init_busy     <= (INIT_CLEAR != 0);
            bus.req_ready <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    if (clr_cnt == LAST) begin
                        state         <= RUN;
                        clr_cnt       <= '0;
                        init_busy     <= 1'b0;
                        bus.req_ready <= 1'b1;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end
                RUN: begin
                    init_busy     <= 1'b0;
                    bus.req_ready <= 1'b1;
                end
                default: state <= RUN;
            endcase
        end
    end

    // valid shift register and out-of-range tag for each accepted read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            oor_q    <= 1'b0;
        end else begin
            vld_pipe <= (vld_pipe << 1) | LAT'(rd_acc);
            if (rd_acc) oor_q <= ~in_range;
        end
    end

    // extra data stages beyond the array's read register
    generate
        if (LAT == 1) begin : g_lat1
            assign out_word = s1_word;
        end else begin : g_latn
            logic [WW-1:0] dly [2:LAT];
            // shift every cycle; the last stage still equals the last valid response when idle
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int s = 2; s <= LAT; s++) dly[s] <= '0;
                end else begin
                    dly[2] <= s1_word;
                    for (int s = 3; s <= LAT; s++) dly[s] <= dly[s-1];
                end
            end
            assign out_word = dly[LAT];
        end
    endgenerate
endmodule

// File: tb/tb_acc_ram_ctrl.sv
// Bench for acc_ram_ctrl: two instances (DEPTH 128 / RD_LAT 3 and DEPTH 100 / RD_LAT 1)
// receive the same request stream; each has its own expected read data.
module tb_acc_ram_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy0, busy1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    acc_ram_ctrl_if #(.DW(16), .AW(7)) bus0 ();
    acc_ram_ctrl_if #(.DW(16), .AW(7)) bus1 ();

    acc_ram_ctrl #(.DW(16), .AW(7), .DEPTH(128), .RD_LAT(3), .INIT_CLEAR(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0), .init_busy(busy0));
    acc_ram_ctrl #(.DW(16), .AW(7), .DEPTH(100), .RD_LAT(1), .INIT_CLEAR(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1), .init_busy(busy1));

    typedef struct {
        logic        wr;
        logic [6:0]  addr;
        logic [15:0] wdata;
        logic        inj;
        logic [15:0] exp0;
        logic [15:0] exp1;
        logic        perr0;
        logic        perr1;
    } vec_t;

    vec_t vecs[$];
    vec_t idle;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    function automatic vec_t wv(input logic [6:0] a, input logic [15:0] d, input logic inj);
        vec_t v;
        v = '{wr: 1'b1, addr: a, wdata: d, inj: inj, exp0: 16'h0, exp1: 16'h0, perr0: 1'b0, perr1: 1'b0};
        return v;
    endfunction

    function automatic vec_t rv(input logic [6:0] a, input logic [15:0] e0, input logic [15:0] e1,
                                input logic p0, input logic p1);
        vec_t v;
        v = '{wr: 1'b0, addr: a, wdata: 16'h0, inj: 1'b0, exp0: e0, exp1: e1, perr0: p0, perr1: p1};
        return v;
    endfunction

    task automatic drive(input vec_t v, input logic valid);
        bus0.req_valid = valid;      bus1.req_valid = valid;
        bus0.req_wr    = v.wr;       bus1.req_wr    = v.wr;
        bus0.req_addr  = v.addr;     bus1.req_addr  = v.addr;
        bus0.req_wdata = v.wdata;    bus1.req_wdata = v.wdata;
`ifdef ACC_RAM_PARITY_EN
        bus0.inj_perr  = v.inj;      bus1.inj_perr  = v.inj;
`endif
    endtask

    // Called at a negedge; returns at a negedge.
    task automatic run_vec(input vec_t v);
        string t;
        t = $sformatf("%s@%0d", v.wr ? "wr" : "rd", v.addr);
        chk({t, " ready0"}, 32'(bus0.req_ready), 1);
        chk({t, " ready1"}, 32'(bus1.req_ready), 1);
        drive(v, 1'b1);
        @(posedge clk);
        @(negedge clk);
        drive(idle, 1'b0);
        if (v.wr) begin
            chk({t, " norsp0"}, 32'(bus0.rsp_valid), 0);
            chk({t, " norsp1"}, 32'(bus1.rsp_valid), 0);
        end else begin
            chk({t, " vld1"}, 32'(bus1.rsp_valid), 1);
            chk({t, " dat1"}, 32'(bus1.rsp_rdata), 32'(v.exp1));
`ifdef ACC_RAM_PARITY_EN
            chk({t, " perr1"}, 32'(bus1.rsp_perr), 32'(v.perr1));
`endif
            chk({t, " early0a"}, 32'(bus0.rsp_valid), 0);
            @(negedge clk);
            chk({t, " pulse1"}, 32'(bus1.rsp_valid), 0);
            chk({t, " hold1"}, 32'(bus1.rsp_rdata), 32'(v.exp1));
            chk({t, " early0b"}, 32'(bus0.rsp_valid), 0);
            @(negedge clk);
            chk({t, " vld0"}, 32'(bus0.rsp_valid), 1);
            chk({t, " dat0"}, 32'(bus0.rsp_rdata), 32'(v.exp0));
`ifdef ACC_RAM_PARITY_EN
            chk({t, " perr0"}, 32'(bus0.rsp_perr), 32'(v.perr0));
`endif
            @(negedge clk);
            chk({t, " pulse0"}, 32'(bus0.rsp_valid), 0);
            chk({t, " hold0"}, 32'(bus0.rsp_rdata), 32'(v.exp0));
        end
    endtask

    // Called at the negedge where rst_n was released; samples 300 cycles.
    task automatic check_clear(input string tag);
        int b0 = 0, b1 = 0, r0 = -1, r1 = -1, nv = 0;
        for (int i = 0; i < 300; i++) begin
            if (busy0) b0++;
            if (busy1) b1++;
            if (r0 < 0 && bus0.req_ready) r0 = i;
            if (r1 < 0 && bus1.req_ready) r1 = i;
            if (bus0.rsp_valid || bus1.rsp_valid) nv++;
            @(negedge clk);
        end
        chk({tag, " busy_cycles0"}, 32'(b0), 128);
        chk({tag, " busy_cycles1"}, 32'(b1), 100);
        chk({tag, " ready_idx0"}, 32'(r0), 128);
        chk({tag, " ready_idx1"}, 32'(r1), 100);
        chk({tag, " stray_rsp"}, 32'(nv), 0);
    endtask

    initial begin
        idle = '{wr: 1'b0, addr: 7'h0, wdata: 16'h0, inj: 1'b0, exp0: 16'h0, exp1: 16'h0,
                 perr0: 1'b0, perr1: 1'b0};
        drive(idle, 1'b0);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst ready0", 32'(bus0.req_ready), 0);
        chk("rst ready1", 32'(bus1.req_ready), 0);
        chk("rst vld0", 32'(bus0.rsp_valid), 0);
        chk("rst dat0", 32'(bus0.rsp_rdata), 0);
        chk("rst busy0", 32'(busy0), 1);
        chk("rst busy1", 32'(busy1), 1);
        rst_n = 1'b1;
        check_clear("por");

        vecs.push_back(rv(7'd25, 16'h0000, 16'h0000, 1'b0, 1'b0));
        vecs.push_back(wv(7'd20, 16'h0002, 1'b0));
        vecs.push_back(wv(7'd24, 16'hFFFB, 1'b0));
        vecs.push_back(wv(7'd10, 16'h1234, 1'b0));
        vecs.push_back(rv(7'd10, 16'h1234, 16'h1234, 1'b0, 1'b0));
        vecs.push_back(wv(7'd120, 16'hAAAA, 1'b0));
        vecs.push_back(rv(7'd120, 16'hAAAA, 16'h0000, 1'b0, 1'b0));
        vecs.push_back(rv(7'd20, 16'h0002, 16'h0002, 1'b0, 1'b0));
        vecs.push_back(wv(7'd99, 16'h7FFF, 1'b0));
        vecs.push_back(rv(7'd99, 16'h7FFF, 16'h7FFF, 1'b0, 1'b0));
        vecs.push_back(wv(7'd127, 16'h8000, 1'b0));
        vecs.push_back(rv(7'd127, 16'h8000, 16'h0000, 1'b0, 1'b0));
        vecs.push_back(wv(7'd0, 16'h5555, 1'b0));
        vecs.push_back(rv(7'd0, 16'h5555, 16'h5555, 1'b0, 1'b0));
        vecs.push_back(wv(7'd5, 16'h00FF, 1'b1));
        vecs.push_back(wv(7'd6, 16'h00FF, 1'b0));
`ifdef ACC_RAM_PARITY_EN
        vecs.push_back(rv(7'd5, 16'h00FF, 16'h00FF, 1'b1, 1'b1));
`else
        vecs.push_back(rv(7'd5, 16'h00FF, 16'h00FF, 1'b0, 1'b0));
`endif
        vecs.push_back(rv(7'd6, 16'h00FF, 16'h00FF, 1'b0, 1'b0));
        vecs.push_back(wv(7'd10, 16'h0001, 1'b0));
        vecs.push_back(rv(7'd10, 16'h0001, 16'h0001, 1'b0, 1'b0));
        foreach (vecs[i]) run_vec(vecs[i]);

        // back-to-back reads 20 then 24
        drive(rv(7'd20, 16'h0, 16'h0, 1'b0, 1'b0), 1'b1);
        @(posedge clk); @(negedge clk);
        drive(rv(7'd24, 16'h0, 16'h0, 1'b0, 1'b0), 1'b1);
        chk("b2b n0 vld1", 32'(bus1.rsp_valid), 1);
        chk("b2b n0 dat1", 32'(bus1.rsp_rdata), 32'h0002);
        chk("b2b n0 vld0", 32'(bus0.rsp_valid), 0);
        @(posedge clk); @(negedge clk);
        drive(idle, 1'b0);
        chk("b2b n1 vld1", 32'(bus1.rsp_valid), 1);
        chk("b2b n1 dat1", 32'(bus1.rsp_rdata), 32'hFFFB);
        chk("b2b n1 vld0", 32'(bus0.rsp_valid), 0);
        @(negedge clk);
        chk("b2b n2 vld0", 32'(bus0.rsp_valid), 1);
        chk("b2b n2 dat0", 32'(bus0.rsp_rdata), 32'h0002);
        chk("b2b n2 vld1", 32'(bus1.rsp_valid), 0);
        @(negedge clk);
        chk("b2b n3 vld0", 32'(bus0.rsp_valid), 1);
        chk("b2b n3 dat0", 32'(bus0.rsp_rdata), 32'hFFFB);
        @(negedge clk);
        chk("b2b n4 vld0", 32'(bus0.rsp_valid), 0);
        chk("b2b n4 hold0", 32'(bus0.rsp_rdata), 32'hFFFB);

        // three reads in flight, then a one-cycle reset pulse
        drive(rv(7'd20, 16'h0, 16'h0, 1'b0, 1'b0), 1'b1);
        @(posedge clk); @(negedge clk);
        drive(rv(7'd24, 16'h0, 16'h0, 1'b0, 1'b0), 1'b1);
        @(posedge clk); @(negedge clk);
        drive(rv(7'd10, 16'h0, 16'h0, 1'b0, 1'b0), 1'b1);
        @(posedge clk); @(negedge clk);
        drive(idle, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("mid rst vld0", 32'(bus0.rsp_valid), 0);
        chk("mid rst dat0", 32'(bus0.rsp_rdata), 0);
        chk("mid rst ready0", 32'(bus0.req_ready), 0);
        chk("mid rst busy0", 32'(busy0), 1);
        @(negedge clk);
        rst_n = 1'b1;
        check_clear("mid");
        run_vec(rv(7'd0, 16'h0000, 16'h0000, 1'b0, 1'b0));
        run_vec(rv(7'd20, 16'h0000, 16'h0000, 1'b0, 1'b0));
        run_vec(rv(7'd127, 16'h0000, 16'h0000, 1'b0, 1'b0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
